// File: rtl/vga_bounce_engine.sv
// VGA timing generator with a bouncing red box, white background and optional green circle.
// Build option: define VGA_BOUNCE_CIRCLE_EN to include the circle hit logic.
module vga_bounce_engine #(
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2,
   parameter int COLOR_W   = 4,
   parameter int BOX_W     = 64,
   parameter int BOX_H     = 48,
   parameter int CIRC_X    = 320,
   parameter int CIRC_Y    = 240,
   parameter int CIRC_R    = 40
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   input  logic [9:0]         SW,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               FRAME_START
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_DISP = 11'(H_DISPLAY);
   localparam logic [10:0] V_DISP = 11'(V_DISPLAY);
   localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FP);
   localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FP);
   localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FP + V_SYNC);

   localparam logic [11:0] H_LIM   = 12'(H_DISPLAY);
   localparam logic [11:0] V_LIM   = 12'(V_DISPLAY);
   localparam logic [11:0] BOX_W12 = 12'(BOX_W);
   localparam logic [11:0] BOX_H12 = 12'(BOX_H);

   localparam logic [COLOR_W-1:0] C_ON  = {COLOR_W{1'b1}};
   localparam logic [COLOR_W-1:0] C_OFF = {COLOR_W{1'b0}};

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_ce;
   logic [10:0]      h_q, h_d, v_q, v_d;
   logic [10:0]      box_x_q, box_x_d, box_y_q, box_y_d;
   logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
   logic             inv_q, inv_d;
   logic             upd;
   logic [11:0]      x_nxt, y_nxt;

   logic de_d, box_d, circ_d, hs_d, vs_d;
   logic de1_q, box1_q, circ1_q, hs1_q, vs1_q;

   logic [3*COLOR_W-1:0] rgb_d, rgb2_q;
   logic                 hs2_q, vs2_q;

   // Returns {direction_is_negative, new_position}; sums are 12 bits so nothing wraps.
   function automatic logic [11:0] axis_next(input logic [10:0] pos, input logic neg,
                                             input logic [3:0] step, input logic [11:0] len,
                                             input logic [11:0] lim);
      logic [11:0] step12;
      logic [11:0] far_edge;
      step12   = {8'd0, step};
      far_edge = {1'b0, pos} + len + step12;
      if (!neg) begin
         if (far_edge > lim) return {1'b1, 11'(lim - len)};
         else                return {1'b0, pos + 11'(step)};
      end else begin
         if ({1'b0, pos} < step12) return {1'b0, 11'd0};
         else                      return {1'b1, pos - 11'(step)};
      end
   endfunction

   // Pixel enable: down-counter, pix_ce on terminal count 0.
   assign pix_ce = (div_q == '0);

   always_comb begin
      div_d = div_q - DIV_ONE;
      if (pix_ce) div_d = DIV_LOAD;
   end

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_ce) begin
         if (h_q == H_LAST) begin
            h_d = 11'd0;
            if (v_q == V_LAST) v_d = 11'd0;
            else               v_d = v_q + 11'd1;
         end else begin
            h_d = h_q + 11'd1;
         end
      end
   end

   assign upd         = pix_ce && (h_q == 11'd0) && (v_q == V_DISP);
   assign FRAME_START = upd;

   always_comb begin
      x_nxt    = axis_next(box_x_q, dx_neg_q, SW[3:0], BOX_W12, H_LIM);
      y_nxt    = axis_next(box_y_q, dy_neg_q, SW[7:4], BOX_H12, V_LIM);
      box_x_d  = box_x_q;
      box_y_d  = box_y_q;
      dx_neg_d = dx_neg_q;
      dy_neg_d = dy_neg_q;
      inv_d    = inv_q;
      if (upd) begin
         inv_d = SW[9];
         if (!SW[8]) begin
            {dx_neg_d, box_x_d} = x_nxt;
            {dy_neg_d, box_y_d} = y_nxt;
         end
      end
   end

   // Stage 1 inputs: display enable, shape hits, raw syncs.
   always_comb begin
      de_d  = (h_q < H_DISP) && (v_q < V_DISP);
      box_d = (h_q >= box_x_q) && ({1'b0, h_q} < ({1'b0, box_x_q} + BOX_W12)) &&
              (v_q >= box_y_q) && ({1'b0, v_q} < ({1'b0, box_y_q} + BOX_H12));
      hs_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
   end

`ifdef VGA_BOUNCE_CIRCLE_EN
   localparam logic signed [11:0] CX      = 12'(CIRC_X);
   localparam logic signed [11:0] CY      = 12'(CIRC_Y);
   localparam logic signed [23:0] CIRC_R2 = 24'(CIRC_R * CIRC_R);

   logic signed [11:0] c_dx, c_dy;
   logic signed [23:0] c_dxw, c_dyw, c_dx2, c_dy2;

   always_comb begin
      c_dx   = $signed({1'b0, h_q}) - CX;
      c_dy   = $signed({1'b0, v_q}) - CY;
      c_dxw  = 24'(c_dx);
      c_dyw  = 24'(c_dy);
      c_dx2  = c_dxw * c_dxw;
      c_dy2  = c_dyw * c_dyw;
      circ_d = (c_dx2 + c_dy2) <= CIRC_R2;
   end
`else
   // No circle in this build; the term is constant 0 for any real geometry.
   assign circ_d = (CIRC_X < 0) && (CIRC_Y < 0) && (CIRC_R < 0);
`endif

   always_comb begin
      rgb_d = {C_OFF, C_OFF, C_OFF};
      if (de1_q) begin
         if (box1_q)       rgb_d = {C_ON,  C_OFF, C_OFF};
         else if (circ1_q) rgb_d = {C_OFF, C_ON,  C_OFF};
         else              rgb_d = {C_ON,  C_ON,  C_ON};
         if (inv_q) rgb_d = ~rgb_d;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         div_q    <= '0;
         h_q      <= 11'd0;
         v_q      <= 11'd0;
         box_x_q  <= 11'd0;
         box_y_q  <= 11'd0;
         dx_neg_q <= 1'b0;
         dy_neg_q <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         box_x_q  <= box_x_d;
         box_y_q  <= box_y_d;
         dx_neg_q <= dx_neg_d;
         dy_neg_q <= dy_neg_d;
         inv_q    <= inv_d;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         de1_q   <= 1'b0;
         box1_q  <= 1'b0;
         circ1_q <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         rgb2_q  <= '0;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
      end else if (pix_ce) begin
         de1_q   <= de_d;
         box1_q  <= box_d;
         circ1_q <= circ_d;
         hs1_q   <= hs_d;
         vs1_q   <= vs_d;
         rgb2_q  <= rgb_d;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   assign {VGA_R, VGA_G, VGA_B} = rgb2_q;
   assign VGA_HS = hs2_q;
   assign VGA_VS = vs2_q;

endmodule

// File: tb/tb_vga_bounce_engine.sv
// Directed bench for vga_bounce_engine on a shrunken raster (56x25 totals, CLK_DIV=2).
// Expected circle colours follow VGA_BOUNCE_CIRCLE_EN.
module tb_vga_bounce_engine;

   localparam int HD = 40, HF = 4, HSY = 8, HB = 4;
   localparam int VD = 20, VF = 1, VSY = 2, VB = 2;
   localparam int HT = HD + HF + HSY + HB;
   localparam int VT = VD + VF + VSY + VB;
   localparam int FRAME_CYC = 2 * HT * VT;
   localparam int BASE = (VT - VD) * HT;

   localparam logic [11:0] RED = 12'hF00, WHT = 12'hFFF, BLK = 12'h000, CYN = 12'h0FF;
`ifdef VGA_BOUNCE_CIRCLE_EN
   localparam logic [11:0] CIRC_IN = 12'h0F0, CIRC_IN_INV = 12'hF0F;
`else
   localparam logic [11:0] CIRC_IN = WHT, CIRC_IN_INV = BLK;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] sw;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, frame_start;

   int checks = 0;
   int errors = 0;
   int pos = 0;

   typedef struct {
      logic [9:0] sw;
      int         ex;
      int         ey;
      int         mode;
   } vec_t;
   vec_t tbl[12];

   always #5 clk = ~clk;

   vga_bounce_engine #(
      .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .CLK_DIV(2), .COLOR_W(4), .BOX_W(8), .BOX_H(4),
      .CIRC_X(20), .CIRC_Y(10), .CIRC_R(5)
   ) dut (
      .CLOCK_50(clk), .RESET(rst), .SW(sw),
      .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
      .VGA_HS(vga_hs), .VGA_VS(vga_vs), .FRAME_START(frame_start)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      pos++;
   endtask

   // Pixel index N (relative to edge 0) is on the outputs after edge N+1.
   task automatic wait_px(input int h, input int v, input int base, input string name, output bit ok);
      int target;
      target = 2 * (base + v * HT + h + 1);
      ok = (pos <= target);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: window passed (pos %0d target %0d)", name, pos, target);
      end
      while (pos < target) tick();
      #1;
   endtask

   task automatic check_px(input int h, input int v, input int base, input logic [11:0] exp,
                           input string name);
      bit ok;
      wait_px(h, v, base, name, ok);
      if (ok) chk(name, 32'({vga_r, vga_g, vga_b}), 32'(exp));
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 2 * FRAME_CYC; k++) begin
         @(negedge clk);
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL frame_start_timeout: got no pulse expected one within %0d cycles", 2 * FRAME_CYC);
      end else begin
         @(posedge clk);
         pos = 0;
         #1;
      end
   endtask

   task automatic measure(input string tag);
      int   hs_low = 0, vs_low = 0, hs_falls = 0, vs_falls = 0;
      logic hs_prev = 1'b1, vs_prev = 1'b1;
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge clk);
         if (!vga_hs) hs_low++;
         if (!vga_vs) vs_low++;
         if (hs_prev && !vga_hs) hs_falls++;
         if (vs_prev && !vga_vs) vs_falls++;
         hs_prev = vga_hs;
         vs_prev = vga_vs;
      end
      chk({tag, "_hs_low"},   32'(hs_low),   32'(VT * 2 * HSY));
      chk({tag, "_vs_low"},   32'(vs_low),   32'(VSY * HT * 2));
      chk({tag, "_hs_falls"}, 32'(hs_falls), 32'(VT));
      chk({tag, "_vs_falls"}, 32'(vs_falls), 32'(1));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'(0));
      chk({tag, "_hs"},    32'(vga_hs), 32'(1));
      chk({tag, "_vs"},    32'(vga_vs), 32'(1));
      chk({tag, "_fs"},    32'(frame_start), 32'(0));
      chk({tag, "_box_x"}, 32'(dut.box_x_q), 32'(0));
      chk({tag, "_box_y"}, 32'(dut.box_y_q), 32'(0));
      chk({tag, "_h"},     32'(dut.h_q), 32'(0));
      chk({tag, "_v"},     32'(dut.v_q), 32'(0));
   endtask

   initial begin
      bit ok;
      // {SW, expected box_x, expected box_y after the update, pixel-check mode}
      tbl[0]  = '{10'h011,  1,  1, 1};
      tbl[1]  = '{10'h0AF, 16, 11, 0};
      tbl[2]  = '{10'h0AF, 31, 16, 0};
      tbl[3]  = '{10'h0AF, 32,  6, 0};
      tbl[4]  = '{10'h1AF, 32,  6, 0};
      tbl[5]  = '{10'h1AF, 32,  6, 0};
      tbl[6]  = '{10'h1AF, 32,  6, 0};
      tbl[7]  = '{10'h0AF, 17,  0, 0};
      tbl[8]  = '{10'h0A0, 17, 10, 0};
      tbl[9]  = '{10'h00F,  2, 10, 0};
      tbl[10] = '{10'h00F,  0, 10, 2};
      tbl[11] = '{10'h201,  1, 10, 3};

      rst = 1'b1;
      sw  = 10'h000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst");
      rst = 1'b0;
      measure("sync");

      sw = tbl[0].sw;
      for (int i = 0; i < 12; i++) begin
         wait_fs(ok);
         if (!ok) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         chk($sformatf("v%0d_box_x", i), 32'(dut.box_x_q), 32'(tbl[i].ex));
         chk($sformatf("v%0d_box_y", i), 32'(dut.box_y_q), 32'(tbl[i].ey));
         @(negedge clk);
         chk($sformatf("v%0d_fs_width", i), 32'(frame_start), 32'(0));
         if (i + 1 < 12) sw = tbl[i + 1].sw;
         case (tbl[i].mode)
            1: begin
               check_px(0, 0, BASE, WHT, "box_px_0_0");
               check_px(1, 0, BASE, WHT, "box_px_1_0");
               check_px(0, 1, BASE, WHT, "box_px_0_1");
               check_px(1, 1, BASE, RED, "box_px_1_1");
               check_px(8, 1, BASE, RED, "box_px_8_1");
               check_px(9, 1, BASE, WHT, "box_px_9_1");
               check_px(1, 4, BASE, RED, "box_px_1_4");
               check_px(1, 5, BASE, WHT, "box_px_1_5");
            end
            2: begin
               check_px(20,  4, BASE, WHT,     "circ_px_20_4");
               check_px(20,  5, BASE, CIRC_IN, "circ_px_20_5");
               check_px(25, 10, BASE, CIRC_IN, "circ_px_25_10");
               check_px(26, 10, BASE, WHT,     "circ_px_26_10");
               check_px(7,  13, BASE, RED,     "box2_px_7_13");
               check_px(8,  13, BASE, WHT,     "box2_px_8_13");
               check_px(7,  14, BASE, WHT,     "box2_px_7_14");
            end
            3: begin
               check_px(0,   0, BASE, BLK,         "inv_px_0_0");
               check_px(40,  0, BASE, BLK,         "inv_px_blank");
               check_px(1,  10, BASE, CYN,         "inv_px_1_10");
               check_px(20, 10, BASE, CIRC_IN_INV, "inv_px_20_10");
            end
            default: ;
         endcase
      end

      // Mid-frame reset while hsync is low on line 11.
      wait_px(HD + HF + 2, 11, BASE, "mid_hs_window", ok);
      chk("mid_hs_low", 32'(vga_hs), 32'(0));
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("mid_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      pos = 0;
      check_px(7, 0, 0, RED, "post_rst_px_7_0");
      check_px(8, 0, 0, WHT, "post_rst_px_8_0");
      measure("post_rst_sync");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
